// File: rtl/pc_redirect_unit.sv
// ----------------------------------------------------------------------------
// pc_redirect_unit: owns the architectural PC, runs the fetch handshake and
// applies commit-time redirects. Optional counter: PC_REDIRECT_CNT_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pc_redirect_unit #(
  parameter int                XLEN     = 64,
  parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            commit,
  input  logic            branch,
  input  logic [XLEN-1:0] branch_target,
  input  logic            ecall,
  input  logic            mret,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  output logic            if_req_valid,
  output logic [XLEN-1:0] if_req_addr,
  input  logic            if_req_ready,
  input  logic            if_resp_valid,
  input  logic [31:0]     if_resp_inst,
  output logic            inst_valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr,
  output logic [XLEN-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            outstanding;
  logic            take;
  logic            check_align;
  logic            misaligned;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] pc_inc;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] pc_next;

  assign trap_base = {mtvec[XLEN-1:2], 2'b00};
  assign pc_inc    = pc + XLEN'(4);
  assign take      = (state == S_EXEC) && commit;

  always_ff @(posedge clk) begin
    if (rst) state <= S_REQ;
    else     state <= state_n;
  end

  // A response only counts while a request accepted since the last reset is pending.
  always_comb begin
    state_n      = state;
    if_req_valid = 1'b0;
    inst_valid   = 1'b0;
    case (state)
      S_REQ: begin
        if_req_valid = !rst;
        if (if_req_ready) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (if_resp_valid && outstanding) state_n = S_EXEC;
      end
      S_EXEC: begin
        inst_valid = 1'b1;
        if (commit) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  assign if_req_addr = pc;

  always_comb begin
    sel_target  = pc_inc;
    check_align = 1'b0;
    if (ecall) begin
      sel_target = trap_base;
    end else if (mret) begin
      sel_target  = mepc;
      check_align = 1'b1;
    end else if (branch) begin
      sel_target  = branch_target;
      check_align = 1'b1;
    end
  end

  assign misaligned = check_align && (sel_target[1:0] != 2'b00);
  assign pc_next    = misaligned ? trap_base : sel_target;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= RESET_PC;
      inst          <= 32'h0;
      outstanding   <= 1'b0;
      misalign_exc  <= 1'b0;
      misalign_addr <= '0;
    end else begin
      misalign_exc <= take && misaligned;
      if (take) pc <= pc_next;
      if (take && misaligned) misalign_addr <= sel_target;
      if (state == S_REQ && if_req_ready)  outstanding <= 1'b1;
      else if (if_resp_valid)              outstanding <= 1'b0;
      if (state == S_WAIT && if_resp_valid && outstanding) inst <= if_resp_inst;
    end
  end

`ifdef PC_REDIRECT_CNT_EN
  logic [XLEN-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      cnt_q <= '0;
    else if (take && (pc_next != pc_inc) && !(&cnt_q))
      cnt_q <= cnt_q + XLEN'(1);
  end

  assign redirect_cnt = cnt_q;
`else
  assign redirect_cnt = '0;
`endif

  logic unused_bits;
  assign unused_bits = &{1'b0, mtvec[1:0]};

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
// Randomized scoreboard bench for pc_redirect_unit with a spec-level PC model.
`default_nettype none

module tb_pc_redirect_unit;

  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst, commit, branch, ecall, mret;
  logic [63:0] branch_target, mtvec, mepc;
  logic        if_req_valid, if_req_ready, if_resp_valid;
  logic [63:0] if_req_addr;
  logic [31:0] if_resp_inst, inst;
  logic        inst_valid, misalign_exc;
  logic [63:0] pc, misalign_addr, redirect_cnt;

  always #5 clk = ~clk;

  pc_redirect_unit dut (
    .clk(clk), .rst(rst), .commit(commit), .branch(branch),
    .branch_target(branch_target), .ecall(ecall), .mret(mret),
    .mtvec(mtvec), .mepc(mepc), .if_req_valid(if_req_valid),
    .if_req_addr(if_req_addr), .if_req_ready(if_req_ready),
    .if_resp_valid(if_resp_valid), .if_resp_inst(if_resp_inst),
    .inst_valid(inst_valid), .inst(inst), .pc(pc),
    .misalign_exc(misalign_exc), .misalign_addr(misalign_addr),
    .redirect_cnt(redirect_cnt)
  );

  typedef struct {
    logic [63:0] pc;
    logic        mis;
    logic [63:0] maddr;
    logic [63:0] cnt;
  } req_exp_t;

  typedef struct {
    logic [31:0] iw;
    logic [63:0] pc;
  } inst_exp_t;

  req_exp_t  req_q[$];
  inst_exp_t inst_q[$];

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc, m_maddr, m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Architectural state after reset, and the first fetch it must produce.
  task automatic model_reset();
    req_exp_t e;
    m_pc = RST_PC; m_maddr = '0; m_cnt = '0;
    req_q.delete();
    inst_q.delete();
    e.pc = m_pc; e.mis = 1'b0; e.maddr = m_maddr; e.cnt = m_cnt;
    req_q.push_back(e);
  endtask

  task automatic model_commit(input bit br, input bit ec, input bit mr,
                              input logic [63:0] tgt, input logic [63:0] tv,
                              input logic [63:0] ep);
    req_exp_t    e;
    logic [63:0] t, inc, np;
    bit          align_chk, mis;
    inc = m_pc + 64'd4;
    align_chk = 1'b1;
    if (ec)      begin t = tv & ~64'h3; align_chk = 1'b0; end
    else if (mr) t = ep;
    else if (br) t = tgt;
    else         begin t = inc; align_chk = 1'b0; end
    mis = align_chk && (t % 4 != 0);
    np  = mis ? (tv & ~64'h3) : t;
    if (mis) m_maddr = t;
`ifdef PC_REDIRECT_CNT_EN
    if (np != inc && m_cnt != 64'hFFFF_FFFF_FFFF_FFFF) m_cnt = m_cnt + 1;
`endif
    m_pc = np;
    e.pc = m_pc; e.mis = mis; e.maddr = m_maddr; e.cnt = m_cnt;
    req_q.push_back(e);
  endtask

  // Monitor: every new fetch request and every new decode presentation is scored.
  logic prev_rv = 1'b0, prev_iv = 1'b0;
  int   gap = 0, last_gap = 0;

  always @(negedge clk) begin : monitor
    req_exp_t  e;
    inst_exp_t ie;
    if (if_req_valid === 1'b1 && prev_rv !== 1'b1) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", 64'd1, 64'd0);
      end else begin
        e = req_q.pop_front();
        chk("req_addr", if_req_addr, e.pc);
        chk("pc", pc, e.pc);
        chk("misalign_exc", {63'd0, misalign_exc}, {63'd0, e.mis});
        chk("misalign_addr", misalign_addr, e.maddr);
        chk("redirect_cnt", redirect_cnt, e.cnt);
      end
    end else if (rst !== 1'b1) begin
      chk("misalign_idle", {63'd0, misalign_exc}, 64'd0);
    end
    if (rst === 1'b1) gap = 0;
    else if (inst_valid === 1'b0) gap++;
    else if (prev_iv !== 1'b1) begin
      last_gap = gap;
      gap = 0;
      if (inst_q.size() == 0) begin
        chk("unexpected_inst", 64'd1, 64'd0);
      end else begin
        ie = inst_q.pop_front();
        chk("inst", {32'd0, inst}, {32'd0, ie.iw});
        chk("inst_pc", pc, ie.pc);
      end
    end
    prev_rv = if_req_valid;
    prev_iv = inst_valid;
  end

  // Noise on inputs that must be ignored outside EXEC.
  task automatic junk();
    commit = 1'($urandom_range(0, 1));
    branch = 1'($urandom_range(0, 1));
    ecall  = 1'($urandom_range(0, 1));
    mret   = 1'($urandom_range(0, 1));
    branch_target = {$urandom, $urandom};
    mepc  = {$urandom, $urandom};
  endtask

  task automatic wait_req(output bit ok);
    int n = 0;
    ok = 1'b1;
    while (if_req_valid !== 1'b1) begin
      @(posedge clk); #1;
      n++;
      if (n > 50) begin
        chk("req_timeout", 64'd1, 64'd0);
        ok = 1'b0;
        return;
      end
    end
  endtask

  task automatic run_instr(input bit br, input bit ec, input bit mr,
                           input logic [63:0] tgt, input logic [63:0] tv,
                           input logic [63:0] ep, input logic [31:0] iw,
                           input int rdy_wait, input int lat, input int ex_wait);
    bit        ok;
    inst_exp_t ie;
    wait_req(ok);
    if (!ok) return;
    repeat (rdy_wait) begin junk(); @(posedge clk); #1; end
    if_req_ready = 1'b1; junk();
    @(posedge clk); #1;
    if_req_ready = 1'b0;
    repeat (lat - 1) begin junk(); @(posedge clk); #1; end
    if_resp_inst = iw; if_resp_valid = 1'b1; junk();
    ie.iw = iw; ie.pc = m_pc;
    inst_q.push_back(ie);
    @(posedge clk); #1;
    if_resp_valid = 1'b0; commit = 1'b0;
    repeat (ex_wait) begin
      branch = 1'($urandom_range(0, 1)); ecall = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    commit = 1'b1; branch = br; ecall = ec; mret = mr;
    branch_target = tgt; mtvec = tv; mepc = ep;
    model_commit(br, ec, mr, tgt, tv, ep);
    @(posedge clk); #1;
    commit = 1'b0; branch = 1'b0; ecall = 1'b0; mret = 1'b0;
  endtask

  // Reset while a fetch is in flight, then offer the stale response.
  task automatic mid_reset();
    bit ok;
    wait_req(ok);
    if (!ok) return;
    if_req_ready = 1'b1;
    @(posedge clk); #1;
    if_req_ready = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("req_low_in_reset", {63'd0, if_req_valid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    if_resp_inst = 32'hDEAD_BEEF; if_resp_valid = 1'b1;
    @(posedge clk); #1;
    if_resp_valid = 1'b0;
    @(negedge clk);
    chk("stale_resp_dropped", {63'd0, inst_valid}, 64'd0);
    chk("pc_after_mid_reset", pc, RST_PC);
    chk("req_after_mid_reset", {63'd0, if_req_valid}, 64'd1);
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] rnd_addr();
    logic [63:0] a;
    a = {$urandom, $urandom};
    if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    rst = 1'b1; commit = 1'b0; branch = 1'b0; ecall = 1'b0; mret = 1'b0;
    branch_target = '0; mtvec = '0; mepc = '0;
    if_req_ready = 1'b0; if_resp_valid = 1'b0; if_resp_inst = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("req_after_reset", {63'd0, if_req_valid}, 64'd1);
    chk("inst_valid_reset", {63'd0, inst_valid}, 64'd0);
    chk("inst_reset", {32'd0, inst}, 64'd0);
    @(posedge clk); #1;

    run_instr(0, 0, 0, '0, 64'h8000_0203, '0, 32'h0000_0013, 0, 1, 0);
    run_instr(0, 0, 0, '0, 64'h8000_0203, '0, 32'h0000_0013, 0, 1, 0);
    chk("decode_gap", 64'(last_gap), 64'd2);
    run_instr(1, 0, 0, 64'h8000_0100, 64'h8000_0203, '0, 32'h0000_0013, 0, 1, 1);
    run_instr(1, 1, 1, 64'h8000_0100, 64'h8000_0203, 64'h8000_0008, 32'h0000_0073, 1, 2, 0);
    run_instr(0, 0, 1, '0, 64'h8000_0203, 64'h8000_0008, 32'h3020_0073, 0, 1, 2);
    run_instr(1, 0, 0, 64'h8000_0102, 64'h8000_0203, '0, 32'h0000_0063, 0, 1, 0);
    run_instr(0, 0, 1, '0, 64'h8000_0203, 64'hFFFF_FFFF_FFFF_FFFC, 32'h3020_0073, 0, 1, 0);
    run_instr(0, 0, 0, '0, 64'h8000_0203, '0, 32'h0000_0013, 0, 1, 0);
    run_instr(0, 1, 0, '0, 64'h1234_5677, '0, 32'h0000_0073, 2, 3, 1);
    mid_reset();

    for (int i = 0; i < 150; i++) begin
      if (i % 50 == 49) mid_reset();
      run_instr(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
                $urandom_range(0, 5) == 0, rnd_addr(), {$urandom, $urandom},
                rnd_addr(), $urandom, $urandom_range(0, 2),
                $urandom_range(1, 3), $urandom_range(0, 2));
    end

    repeat (5) @(posedge clk);
    chk("req_queue_drained", 64'(req_q.size()), 64'd0);
    chk("inst_queue_drained", 64'(inst_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Consumer end of the branch-decision interface: owns the architectural PC and applies taken-branch, jump, ecall and mret redirects.
- Drives the instruction-fetch request/response handshake and presents the fetched instruction plus its PC to decode.
- Holds each instruction in an EXEC state until the core signals commit, then computes the next PC.
- Sits between the branch-decision/CSR logic and the fetch memory port.

Parameters:
- RESET_PC, 64'h8000_0000, PC loaded on reset.
- XLEN, 64, PC and target width.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- commit  in  1  current instruction retires this cycle; sampled only in EXEC.
- branch  in  1  redirect-taken decision, valid while commit=1.
- branch_target  in  64  jal/branch/jalr target; jalr bit0 already cleared upstream.
- ecall  in  1  trap entry, valid with commit.
- mret  in  1  trap return, valid with commit.
- mtvec  in  64  trap vector (direct mode, low 2 bits ignored).
- mepc  in  64  return address for mret.
- if_req_valid  out  1  fetch request valid.
- if_req_addr  out  64  fetch address, equal to pc.
- if_req_ready  in  1  memory accepts the request.
- if_resp_valid  in  1  instruction word returned.
- if_resp_inst  in  32  returned instruction.
- inst_valid  out  1  inst/pc valid for decode (high in EXEC).
- inst  out  32  latched instruction.
- pc  out  64  architectural PC.
- misalign_exc  out  1  one-cycle pulse: selected target not 4-byte aligned.
- misalign_addr  out  64  offending target, held until next pulse.
- redirect_cnt  out  64  count of non-sequential PC updates (see Optional Feature).

Behaviour:
- Reset values: pc=RESET_PC; state=REQ; if_req_valid=0 during the reset cycle; inst_valid=0; inst=32'h0; misalign_exc=0; misalign_addr=0; redirect_cnt=0.
- rst at any point, including mid-fetch, returns to REQ next cycle. A late if_resp_valid for a request issued before reset is dropped; track it with an outstanding flag that also clears on reset.
- FSM states:
  - REQ: if_req_valid=1, if_req_addr=pc. On if_req_ready, go to WAIT.
  - WAIT: if_req_valid=0. On if_resp_valid, latch inst and go to EXEC. if_resp_valid in the same cycle as the REQ handshake is not allowed; the minimum latency is 1 cycle.
  - EXEC: inst_valid=1. Stay until commit=1, then update pc and go to REQ.
- Next-PC priority on commit:
  - ecall: mtvec&~3
  - else mret: mepc
  - else branch: branch_target
  - else pc+4
- pc+4 wraps modulo 2^64 with no exception.
- If the selected target has [1:0]!=0 (mret or branch path only):
  - misalign_exc=1 for exactly one cycle.
  - misalign_addr=target.
  - pc=mtvec&~3.
- Simultaneous ecall and mret: ecall wins. branch is ignored whenever ecall or mret is set.
- commit, branch, ecall and mret are ignored outside EXEC.
- Fetch loop latency with single-cycle ready and response: REQ→WAIT→EXEC takes 2 cycles. Commit in EXEC produces the new pc on the next cycle, with if_req_valid high in the same cycle.

Optional Feature:
- Macro: PC_REDIRECT_CNT_EN.
- Defined: redirect_cnt increments by 1 on every commit whose next pc != pc+4. This covers ecall, mret, taken branch, and misalign redirect; a misaligned branch or mret counts once. The counter saturates at all-ones.
- Undefined: no counter register is built and redirect_cnt is tied to 64'h0.

Test Plan:
- Reset: hold rst for 2 cycles, then release → pc=64'h8000_0000, if_req_valid=1 and if_req_addr=64'h8000_0000 in the cycle after release.
- Sequential: ready=1, response 1 cycle later with inst=32'h00000013, commit with no redirect → next pc=64'h8000_0004, inst_valid low for exactly 2 cycles between instructions.
- Branch: commit with branch=1 and branch_target=64'h8000_0100 → pc=64'h8000_0100; redirect_cnt=1 if the macro is defined, else 0.
- Traps: mtvec=64'h8000_0203 with ecall=1, mret=1 and branch=1 together → pc=64'h8000_0200. Then mret with mepc=64'h8000_0008 → pc=64'h8000_0008.
- Misaligned: branch_target=64'h8000_0102 → misalign_exc pulses 1 cycle, misalign_addr=64'h8000_0102, pc=mtvec&~3.
- Reset mid-operation: assert rst in WAIT, then deliver a stale if_resp_valid after release → response ignored, FSM restarts at REQ with pc=RESET_PC.
